// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bundle for branch_predict_unit.
// Stats outputs appear only with BRANCH_STATS_EN.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lookup_pc;
  logic            predict_taken;
  logic            ready;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic            res_pred_taken;
  logic [2:0]      func3;
  logic            branch_operation;
  logic            jump_operation;
  logic            zero_flag;
  logic            SLT_flag;
  logic            SLTu_flag;
  logic            is_true;
  logic            mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output lookup_pc, res_valid, res_pc,
    output res_pred_taken, func3,
    output branch_operation, jump_operation,
    output zero_flag, SLT_flag, SLTu_flag,
    input  predict_taken, ready,
    input  is_true, mispredict,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, res_valid, res_pc,
    input  res_pred_taken, func3,
    input  branch_operation, jump_operation,
    input  zero_flag, SLT_flag, SLTu_flag,
    output predict_taken, ready,
    output is_true, mispredict,
    output branch_count, mispredict_count
  );
`else
  modport master (
    output lookup_pc, res_valid, res_pc,
    output res_pred_taken, func3,
    output branch_operation, jump_operation,
    output zero_flag, SLT_flag, SLTu_flag,
    input  predict_taken, ready,
    input  is_true, mispredict
  );

  modport slave (
    input  lookup_pc, res_valid, res_pc,
    input  res_pred_taken, func3,
    input  branch_operation, jump_operation,
    input  zero_flag, SLT_flag, SLTu_flag,
    output predict_taken, ready,
    output is_true, mispredict
  );
`endif
endinterface

// File: rtl/branch_predict_unit.sv
// Branch condition resolve plus 2-bit BHT predictor.
// Optional macro BRANCH_STATS_EN adds branch/mispredict counters.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_init_idx;
  logic [IDX_W-1:0] w_init_idx_nxt;
  logic             w_init_we;
  logic             w_ready;
  logic [1:0]       r_bht [BHT_ENTRIES];
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic [1:0]       w_res_cnt;
  logic [1:0]       w_res_cnt_nxt;
  logic             w_legal;
  logic             w_is_true;
  logic             w_upd;
  logic             w_mis_nxt;
  logic             r_mispredict;
  logic             w_unused_pc;

  assign w_lk_idx  = bus.lookup_pc[IDX_W+1:2];
  assign w_res_idx = bus.res_pc[IDX_W+1:2];

  assign w_unused_pc = ^{bus.lookup_pc[XLEN-1:IDX_W+2],
                         bus.lookup_pc[1:0],
                         bus.res_pc[XLEN-1:IDX_W+2],
                         bus.res_pc[1:0]};

  // FSM state and init-index register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // FSM next state: sweep every entry once, then run
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_init_we      = 1'b0;
    w_ready        = 1'b0;
    unique case (r_state)
      S_INIT: begin
        w_init_we      = 1'b1;
        w_init_idx_nxt = r_init_idx + IDX_W'(1);
        if (r_init_idx == IDX_W'(BHT_ENTRIES - 1))
          w_state_nxt = S_RUN;
      end
      S_RUN:   w_ready = 1'b1;
      default: ;
    endcase
  end

  // Branch condition decode; branch wins over jump
  always_comb begin
    w_is_true = 1'b0;
    w_legal   = 1'b0;
    priority case (1'b1)
      bus.branch_operation: begin
        w_legal = 1'b1;
        case (bus.func3)
          3'b000: w_is_true = bus.zero_flag;
          3'b001: w_is_true = ~bus.zero_flag;
          3'b100: w_is_true = bus.SLT_flag;
          3'b101: w_is_true = ~(bus.zero_flag | bus.SLT_flag);
          3'b110: w_is_true = bus.SLTu_flag;
          3'b111: w_is_true = ~(bus.zero_flag | bus.SLTu_flag);
          default: w_legal  = 1'b0;
        endcase
      end
      bus.jump_operation: w_is_true = 1'b1;
      default: ;
    endcase
  end

  // Saturating next value for the resolved entry
  always_comb begin
    w_res_cnt     = r_bht[w_res_idx];
    w_res_cnt_nxt = w_res_cnt;
    if (w_is_true && w_res_cnt != 2'b11)
      w_res_cnt_nxt = w_res_cnt + 2'b01;
    else if (!w_is_true && w_res_cnt != 2'b00)
      w_res_cnt_nxt = w_res_cnt - 2'b01;
  end

  assign w_upd = w_ready & bus.res_valid & w_legal & ~rst;

  assign w_mis_nxt = w_ready & bus.res_valid
                   & (bus.branch_operation | bus.jump_operation)
                   & (w_is_true ^ bus.res_pred_taken);

  // BHT storage: init sweep or resolve update
  always_ff @(posedge clk) begin
    if (w_init_we && !rst)
      r_bht[r_init_idx] <= CNT_INIT;
    else if (w_upd)
      r_bht[w_res_idx] <= w_res_cnt_nxt;
  end

  // Registered mispredict pulse
  always_ff @(posedge clk) begin
    if (rst) r_mispredict <= 1'b0;
    else     r_mispredict <= w_mis_nxt;
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;
  logic        w_accept;

  assign w_accept = w_ready & bus.res_valid
                  & (bus.branch_operation | bus.jump_operation);

  // Wrapping event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_accept)
        r_branch_count <= r_branch_count + 32'd1;
      if (w_mis_nxt)
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;
`endif

  assign bus.ready         = w_ready;
  assign bus.predict_taken = w_ready & r_bht[w_lk_idx][1];
  assign bus.is_true       = w_is_true;
  assign bus.mispredict    = r_mispredict;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: reference model
// compared every cycle plus directed literal checks.
module tb_branch_predict_unit;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32)) bus ();

  branch_predict_unit #(
    .XLEN(32),
    .BHT_ENTRIES(N),
    .CNT_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int m_cnt [N];
  int m_age;
  bit m_mis;
  int unsigned m_brc;
  int unsigned m_mpc;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_taken(bit br, bit jmp, int f3,
                                 bit z, bit lt, bit ltu);
    if (br) begin
      case (f3)
        0: return z;
        1: return !z;
        4: return lt;
        5: return !z && !lt;
        6: return ltu;
        7: return !z && !ltu;
        default: return 1'b0;
      endcase
    end
    return jmp;
  endfunction

  function automatic bit m_cur_taken();
    return m_taken(bus.branch_operation, bus.jump_operation,
                   int'(bus.func3), bus.zero_flag,
                   bus.SLT_flag, bus.SLTu_flag);
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference model advances on each rising edge
  always @(posedge clk) begin
    bit rdy;
    bit t;
    bit acc;
    int f3;
    rdy = (m_age >= N);
    t   = m_cur_taken();
    f3  = int'(bus.func3);
    acc = rdy && bus.res_valid
       && (bus.branch_operation || bus.jump_operation);
    if (rst) begin
      m_age = 0;
      m_mis = 1'b0;
      m_brc = 0;
      m_mpc = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 1;
      chk_en = 1'b1;
    end else begin
      m_mis = acc && (t != bus.res_pred_taken);
      if (acc) m_brc++;
      if (m_mis) m_mpc++;
      if (rdy && bus.res_valid && bus.branch_operation
          && f3 != 2 && f3 != 3) begin
        if (t) m_cnt[m_idx(bus.res_pc)] =
                 (m_cnt[m_idx(bus.res_pc)] < 3)
                 ? m_cnt[m_idx(bus.res_pc)] + 1 : 3;
        else   m_cnt[m_idx(bus.res_pc)] =
                 (m_cnt[m_idx(bus.res_pc)] > 0)
                 ? m_cnt[m_idx(bus.res_pc)] - 1 : 0;
      end
      if (m_age < N) m_age++;
    end
  end

  // Compare DUT with model away from the active edge
  always @(negedge clk) begin
    bit rdy;
    if (chk_en) begin
      rdy = (m_age >= N);
      chk("ready", 32'(bus.ready), 32'(rdy));
      chk("predict_taken", 32'(bus.predict_taken),
          32'(rdy && m_cnt[m_idx(bus.lookup_pc)] >= 2));
      chk("is_true", 32'(bus.is_true), 32'(m_cur_taken()));
      chk("mispredict", 32'(bus.mispredict), 32'(m_mis));
`ifdef BRANCH_STATS_EN
      chk("branch_count", bus.branch_count, m_brc);
      chk("mispredict_count", bus.mispredict_count, m_mpc);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(bit v, logic [31:0] pc, bit pred,
                     logic [2:0] f3, bit br, bit jmp,
                     bit z, bit lt, bit ltu);
    bus.res_valid        = v;
    bus.res_pc           = pc;
    bus.res_pred_taken   = pred;
    bus.func3            = f3;
    bus.branch_operation = br;
    bus.jump_operation   = jmp;
    bus.zero_flag        = z;
    bus.SLT_flag         = lt;
    bus.SLTu_flag        = ltu;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.lookup_pc = '0;
    res(0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    n = 0;
    forever begin
      @(negedge clk);
      if (bus.ready || n > 200) break;
      n++;
      #2 bus.lookup_pc = 32'(n * 4);
    end
    chk("init_cycles", 32'(n), 32'd64);
    tick();

    bus.lookup_pc = 32'h100;
    res(1, 32'h100, 0, 3'd0, 1, 0, 1, 0, 0);
    #1 chk("pred_untrained", 32'(bus.predict_taken), 32'd0);
    tick();
    chk("pred_train1", 32'(bus.predict_taken), 32'd1);
    tick();
    tick();
    chk("pred_train3", 32'(bus.predict_taken), 32'd1);
    chk("model_sat", 32'(m_cnt[0]), 32'd3);
    bus.res_valid = 1'b0;

    res(0, 32'h100, 0, 3'd5, 1, 0, 0, 0, 0);
    #1 chk("dec_101", 32'(bus.is_true), 32'd1);
    res(0, 32'h100, 0, 3'd7, 1, 0, 0, 0, 1);
    #1 chk("dec_111", 32'(bus.is_true), 32'd0);
    res(1, 32'h100, 0, 3'd2, 1, 0, 1, 0, 0);
    #1 chk("dec_010", 32'(bus.is_true), 32'd0);
    tick();
    tick();
    chk("illegal_noupd", 32'(m_cnt[0]), 32'd3);

    res(1, 32'h104, 0, 3'd0, 0, 1, 0, 0, 0);
    #1 chk("jump_true", 32'(bus.is_true), 32'd1);
    tick();
    chk("jump_mis", 32'(bus.mispredict), 32'd1);
    bus.res_valid = 1'b0;
    bus.lookup_pc = 32'h104;
    #1 chk("jump_noupd", 32'(bus.predict_taken), 32'd0);
    bus.lookup_pc = 32'h100;

    res(1, 32'h108, 1, 3'd1, 1, 0, 1, 0, 0);
    tick();
    bus.res_valid = 1'b0;
    chk("bne_mis", 32'(bus.mispredict), 32'd1);
    tick();
    chk("bne_pulse", 32'(bus.mispredict), 32'd0);
    res(1, 32'h108, 0, 3'd1, 1, 0, 1, 0, 0);
    tick();
    bus.res_valid = 1'b0;
    chk("bne_nomis", 32'(bus.mispredict), 32'd0);

    res(1, 32'h100, 0, 3'd1, 1, 0, 1, 0, 0);
    tick();
    tick();
    res(1, 32'h200, 0, 3'd0, 1, 0, 1, 0, 0);
    #1 chk("collide_old", 32'(bus.predict_taken), 32'd0);
    tick();
    chk("collide_new", 32'(bus.predict_taken), 32'd1);
    bus.res_valid = 1'b0;
    tick();

    res(1, 32'h100, 0, 3'd0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_mis", 32'(bus.mispredict), 32'd0);
    rst = 1'b0;
    bus.res_valid = 1'b0;
    repeat (N) tick();
    chk("reinit_ready", 32'(bus.ready), 32'd1);
    chk("reinit_pred", 32'(bus.predict_taken), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("reinit_brc", bus.branch_count, 32'd0);
    chk("reinit_mpc", bus.mispredict_count, 32'd0);
`endif
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
